ps2_keyboard_rx: RTL and testbench

- Receives PS/2 keyboard frames from the PS2_CLK/PS2_DATA pins and decodes the E0 (extended) and F0 (break) prefixes.
- Emits one event per key press or release, as a scan code plus flags and a one-cycle strobe.
- Sits directly downstream of the PS/2 pins in TOP and feeds the BBC keyboard-matrix emulation.
- Runs entirely in the CLK100MHZ domain; PS2_CLK is sampled as data, never used as a clock.

---
 rtl/ps2_keyboard_rx.sv | 129 ++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver with E0/F0 prefix decode.
// Ports:
//   CLK100MHZ    system clock
//   CPU_RESETN   asynchronous active-low reset
//   PS2_CLK      keyboard clock pin, sampled as data
//   PS2_DATA     keyboard data pin
//   KEY_CODE     last delivered scan code
//   KEY_EXTENDED KEY_CODE was preceded by E0
//   KEY_BREAK    KEY_CODE was preceded by F0
//   KEY_VALID    one-cycle strobe, key outputs valid
//   PARITY_ERR   one-cycle strobe, odd-parity failure
//   FRAME_ERR    one-cycle strobe, bad stop bit or timeout
module ps2_keyboard_rx #(
   parameter int TIMEOUT_CYCLES = 200000,
   parameter bit CHECK_PARITY   = 1'b0
) (
   input  logic       CLK100MHZ,
   input  logic       CPU_RESETN,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic [7:0] KEY_CODE,
   output logic       KEY_EXTENDED,
   output logic       KEY_BREAK,
   output logic       KEY_VALID,
   output logic       PARITY_ERR,
   output logic       FRAME_ERR
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state;
   logic [1:0] clk_sync, data_sync;
   logic clk_prev, fall, data_bit;
   logic [2:0] bit_cnt;
   logic [7:0] shift, byte_q;
   logic par, perr_q, done, abort, ext, brk;
   logic [TW-1:0] tmo_cnt;
   assign fall     = clk_prev & ~clk_sync[1];
   assign data_bit = data_sync[1];
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
      if (!CPU_RESETN) begin
         clk_sync  <= '0;
         data_sync <= '0;
         clk_prev  <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], PS2_CLK};
         data_sync <= {data_sync[0], PS2_DATA};
         clk_prev  <= clk_sync[1];
      end
   // Frame FSM; done/abort are one-cycle handoffs to the decode stage so a
   // new start bit can be accepted while the previous byte is decoded.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
      if (!CPU_RESETN) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shift   <= '0;
         par     <= 1'b0;
         tmo_cnt <= '0;
         done    <= 1'b0;
         abort   <= 1'b0;
         byte_q  <= '0;
         perr_q  <= 1'b0;
      end else begin
         done  <= 1'b0;
         abort <= 1'b0;
         tmo_cnt <= (state == IDLE || fall) ? '0 :
                    (tmo_cnt == TW'(TIMEOUT_CYCLES)) ? tmo_cnt : tmo_cnt + 1'b1;
         if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            abort <= 1'b1;
         end else if (fall) begin
            case (state)
               IDLE: if (!data_bit) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
               DATA: begin
                  shift   <= {data_bit, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= data_bit;
                  state <= STOP;
               end
               default: begin
                  state  <= IDLE;
                  byte_q <= shift;
                  perr_q <= ~(^shift ^ par);
                  done   <= data_bit;
                  abort  <= ~data_bit;
               end
            endcase
         end
      end
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
      if (!CPU_RESETN) begin
         KEY_CODE     <= '0;
         KEY_EXTENDED <= 1'b0;
         KEY_BREAK    <= 1'b0;
         KEY_VALID    <= 1'b0;
         PARITY_ERR   <= 1'b0;
         FRAME_ERR    <= 1'b0;
         ext          <= 1'b0;
         brk          <= 1'b0;
      end else begin
         KEY_VALID  <= 1'b0;
         PARITY_ERR <= 1'b0;
         FRAME_ERR  <= 1'b0;
         if (abort) begin
            FRAME_ERR <= 1'b1;
            ext       <= 1'b0;
            brk       <= 1'b0;
         end else if (done) begin
            PARITY_ERR <= perr_q;
            if (!(perr_q && CHECK_PARITY)) begin
               if (byte_q == 8'hE0) ext <= 1'b1;
               else if (byte_q == 8'hF0) brk <= 1'b1;
               else begin
                  KEY_VALID    <= 1'b1;
                  KEY_CODE     <= byte_q;
                  KEY_EXTENDED <= ext;
                  KEY_BREAK    <= brk;
                  ext          <= 1'b0;
                  brk          <= 1'b0;
               end
            end
         end
      end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed PS/2 frames against an event-queue model, both parity modes.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;
   localparam int T    = 1000;
   localparam int HALF = 50;
   logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [7:0] kc [2];
   logic ke [2], kb [2], kv [2], pe [2], fe [2];
   int cyc = 0, vectors = 0, miscompares = 0;
   typedef struct {
      int due;
      logic [7:0] code;
      logic [1:0] v, ext, brk;
      logic pe, fe;
   } ev_t;
   ev_t q[$];
   logic [7:0] h_code [2];
   logic h_ext [2], h_brk [2];
   bit p_ext [2], p_brk [2];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   ps2_keyboard_rx #(.TIMEOUT_CYCLES(T), .CHECK_PARITY(1'b0)) u0 (
      .CLK100MHZ(clk), .CPU_RESETN(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
      .KEY_CODE(kc[0]), .KEY_EXTENDED(ke[0]), .KEY_BREAK(kb[0]),
      .KEY_VALID(kv[0]), .PARITY_ERR(pe[0]), .FRAME_ERR(fe[0]));
   ps2_keyboard_rx #(.TIMEOUT_CYCLES(T), .CHECK_PARITY(1'b1)) u1 (
      .CLK100MHZ(clk), .CPU_RESETN(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
      .KEY_CODE(kc[1]), .KEY_EXTENDED(ke[1]), .KEY_BREAK(kb[1]),
      .KEY_VALID(kv[1]), .PARITY_ERR(pe[1]), .FRAME_ERR(fe[1]));
   // Model: a finished frame produces at most one event per instance, visible
   // 4 cycles after the stop-bit pin fall (timeout: T cycles later still).
   task automatic model_frame(input logic [7:0] b, input bit bad, input bit stop, input int c);
      ev_t e;
      e = '{due: c + 4, code: b, v: 2'b00, ext: 2'b00, brk: 2'b00, pe: 1'b0, fe: 1'b0};
      for (int i = 0; i < 2; i++) begin
         if (!stop) begin
            e.fe = 1'b1;
            p_ext[i] = 0;
            p_brk[i] = 0;
         end else begin
            e.pe = bad;
            if (!(bad && i == 1)) begin
               if (b == 8'hE0) p_ext[i] = 1;
               else if (b == 8'hF0) p_brk[i] = 1;
               else begin
                  e.v[i] = 1'b1;
                  e.ext[i] = p_ext[i];
                  e.brk[i] = p_brk[i];
                  p_ext[i] = 0;
                  p_brk[i] = 0;
               end
            end
         end
      end
      if (e.v != 2'b00 || e.pe || e.fe) q.push_back(e);
   endtask
   task automatic model_timeout(input int c);
      ev_t e;
      e = '{due: c + 4 + T, code: 8'h00, v: 2'b00, ext: 2'b00, brk: 2'b00, pe: 1'b0, fe: 1'b1};
      q.push_back(e);
      for (int i = 0; i < 2; i++) begin
         p_ext[i] = 0;
         p_brk[i] = 0;
      end
   endtask
   // n bits of the frame (start, data LSB first, parity, stop); mdl=0 sends without modelling.
   task automatic send(input logic [7:0] b, input bit bad, input bit stop, input int n, input bit mdl);
      logic [10:0] bits;
      bits = {stop, (~^b) ^ bad, b, 1'b0};
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == n - 1 && mdl) begin
            if (n == 11) model_frame(b, bad, stop, cyc);
            else model_timeout(cyc);
         end
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      @(negedge clk);
      ps2_data = 1'b1;
   endtask
   task automatic key(input logic [7:0] b);
      send(b, 1'b0, 1'b1, 11, 1'b1);
   endtask
   task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask
   always @(negedge clk) begin : compare
      ev_t e;
      logic [12:0] act, exp_v;
      logic [1:0] sv;
      logic spe, sfe;
      sv = 2'b00;
      spe = 1'b0;
      sfe = 1'b0;
      if (!rst_n) begin
         q.delete();
         for (int i = 0; i < 2; i++) begin
            h_code[i] = 8'h00;
            h_ext[i] = 1'b0;
            h_brk[i] = 1'b0;
         end
      end else if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         sv = e.v;
         spe = e.pe;
         sfe = e.fe;
         for (int i = 0; i < 2; i++)
            if (e.v[i]) begin
               h_code[i] = e.code;
               h_ext[i] = e.ext[i];
               h_brk[i] = e.brk[i];
            end
      end
      for (int i = 0; i < 2; i++) begin
         act = {kv[i], pe[i], fe[i], kc[i], ke[i], kb[i]};
         exp_v = {sv[i], spe, sfe, h_code[i], h_ext[i], h_brk[i]};
         vectors++;
         if (act !== exp_v) begin
            miscompares++;
            if (miscompares < 30)
               $display("FAIL cycle %0d dut%0d {valid,perr,ferr,code,ext,brk} got=%h exp=%h", cyc, i, act, exp_v);
         end
      end
   end
   initial begin
      repeat (5) @(negedge clk);
      lit("reset_code", kc[0], 8'h00);
      lit("reset_strobes", {5'b0, kv[0], pe[0], fe[0]}, 8'h00);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      key(8'h1C);
      lit("make_code", kc[0], 8'h1C);
      lit("make_flags", {ke[0], kb[0]}, 8'h00);
      key(8'hF0); key(8'h1C);
      lit("break_brk", kb[0], 8'h01);
      key(8'h1C);
      lit("after_break_brk", kb[0], 8'h00);
      key(8'hE0); key(8'hF0); key(8'h75);
      lit("ext_break", {kc[0][7:0]}, 8'h75);
      lit("ext_break_flags", {ke[0], kb[0]}, 8'h03);
      key(8'hE0); key(8'h75);
      lit("ext_make_flags", {ke[0], kb[0]}, 8'h02);
      key(8'hF0); key(8'hE0); key(8'h6B);
      lit("rev_prefix_flags", {ke[0], kb[0]}, 8'h03);
      key(8'hE0); key(8'hE0); key(8'h75);
      lit("repeat_prefix_flags", {ke[0], kb[0]}, 8'h02);
      send(8'h12, 1'b1, 1'b1, 11, 1'b1);
      lit("bad_par_cp0_code", kc[0], 8'h12);
      lit("bad_par_cp1_code", kc[1], 8'h75);
      send(8'h55, 1'b0, 1'b0, 11, 1'b1);
      key(8'hF0);
      send(8'h1C, 1'b0, 1'b0, 11, 1'b1);
      key(8'h55);
      lit("ferr_clears_brk", {kc[0][7:1], kb[0]}, 8'h54);
      send(8'h33, 1'b0, 1'b1, 5, 1'b1);
      repeat (T + 100) @(negedge clk);
      key(8'h5A);
      lit("after_timeout", kc[0], 8'h5A);
      lit("after_timeout_flags", {ke[0], kb[0]}, 8'h00);
      send(8'h3A, 1'b0, 1'b1, 6, 1'b0);
      #3 rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         p_ext[i] = 0;
         p_brk[i] = 0;
      end
      #1;
      lit("midreset_code0", kc[0], 8'h00);
      lit("midreset_code1", kc[1], 8'h00);
      lit("midreset_strobes", {2'b0, kv[0], pe[0], fe[0], kv[1], pe[1], fe[1]}, 8'h00);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      key(8'h29);
      lit("post_reset_code0", kc[0], 8'h29);
      lit("post_reset_code1", kc[1], 8'h29);
      repeat (20) @(negedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL pending_events got=%0d exp=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
